// File: rtl/rom_streamer.sv
// Read sequencer for the synchronous rom: walks an address window and streams words on valid/ready.
// Define ROM_STREAMER_LOOP_EN to replay the window until stop instead of making a single pass.
module rom_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  stop,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   len_r;
    logic [ADDR_WIDTH:0]   iss;
    logic                  pend;
    logic [1:0]            cnt;
    logic [DATA_WIDTH-1:0] b0, b1;
    logic                  pop, issue, last_issue, busy_nx;
    logic [2:0]            occ;
`ifdef ROM_STREAMER_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_r;
`endif

    assign pop        = dout_vld & dout_rdy;
    assign dout       = b0;
    assign dout_vld   = (cnt != 2'd0);
    assign done       = (state == DONE);
    assign last_issue = (iss == len_r - LEN_ONE);
    // Occupancy after this edge if one more read were launched now.
    assign occ        = 3'(cnt) + 3'(pend) + 3'd1 - 3'(pop);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (len != '0) ? RUN : DONE;
            end
            RUN: begin
                issue = !stop && (occ <= 3'd2);
                if (stop) begin
                    state_nx = DRAIN;
                end else if (issue && last_issue) begin
`ifdef ROM_STREAMER_LOOP_EN
                    state_nx = RUN;
`else
                    state_nx = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (!pend && cnt == 2'(pop)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == RUN) || (state_nx == DRAIN) ||
                  (state == IDLE && start && len == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // rom_addr is preloaded on start; an issue means rom samples the current rom_addr this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            len_r    <= '0;
            iss      <= '0;
            pend     <= 1'b0;
            busy     <= 1'b0;
`ifdef ROM_STREAMER_LOOP_EN
            base_r   <= '0;
`endif
        end else begin
            busy <= busy_nx;
            pend <= issue;
            if (state == IDLE && start) begin
                len_r <= len;
                iss   <= '0;
`ifdef ROM_STREAMER_LOOP_EN
                base_r <= base_addr;
`endif
                if (len != '0) rom_addr <= base_addr;
            end else if (issue) begin
`ifdef ROM_STREAMER_LOOP_EN
                if (last_issue) begin
                    rom_addr <= base_r;
                    iss      <= '0;
                end else begin
                    rom_addr <= rom_addr + ADDR_ONE;
                    iss      <= iss + LEN_ONE;
                end
`else
                rom_addr <= rom_addr + ADDR_ONE;
                iss      <= iss + LEN_ONE;
`endif
            end
        end
    end

    // Two-entry buffer: b0 is the head; the landing word goes to the first free slot after any pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            b0  <= '0;
            b1  <= '0;
        end else begin
            cnt <= cnt + 2'(pend) - 2'(pop);
            unique case ({pend, pop})
                2'b10: begin
                    if (cnt == 2'd0) b0 <= rom_q;
                    else             b1 <= rom_q;
                end
                2'b01: b0 <= b1;
                2'b11: begin
                    if (cnt == 2'd1) begin
                        b0 <= rom_q;
                    end else begin
                        b0 <= b1;
                        b1 <= rom_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// Self-checking bench for rom_streamer: ROM model, table-driven commands, random backpressure, corner sequences.
module tb_rom_streamer;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          dout_rdy = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] dout;
    logic          dout_vld, busy, done;

    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= mem[rom_addr];

    rom_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .stop(stop), .rom_addr(rom_addr), .rom_q(rom_q), .dout(dout),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .busy(busy), .done(done)
    );

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        int            rdy_mode;   // 1 random with pct, 2 fixed 1,0,0,1 pattern
        int            pct;
        int            exp_words;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            cyc = 0;
    int            rdy_mode = 0;
    int            rdy_pct = 100;
    logic [DW-1:0] got [$];
    bit            pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    vec_t          vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_word(input int base, input int i);
        return mem[(base + i) % DEPTH];
    endfunction

    // Observe at the falling edge (transfers, done pulses, stall stability), then move to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (pv && !pr) begin
                check("stall_vld", dout_vld, 1);
                check("stall_data", dout, pd);
            end
            if (dout_vld && dout_rdy) got.push_back(dout);
            if (done) done_cnt++;
            pv = dout_vld; pr = dout_rdy; pd = dout;
        end else begin
            pv = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            1: dout_rdy = ($urandom_range(0, 99) < rdy_pct);
            2: dout_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: ;
        endcase
    endtask

    task automatic issue_cmd(input logic [AW-1:0] b, input int n);
        base_addr = b;
        len = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_cmd(input int d0, input int idx0, input int base, input int nexp, input bit upto);
        bit ok = 1'b0;
        int n;
        for (int i = 0; i < 4000 && !ok; i++) begin
            tick();
            if (done_cnt > d0) ok = 1'b1;
        end
        check("done_seen", 32'(ok), 1);
        tick();
        check("busy_after_done", 32'(busy), 0);
        check("done_pulses", done_cnt - d0, 1);
        n = got.size() - idx0;
        if (upto) check("words_at_most", 32'(n <= nexp), 1);
        else      check("word_count", n, nexp);
        for (int i = 0; i < n && i < nexp; i++)
            check("word", got[idx0 + i], ref_word(base, i));
    endtask

    initial begin
        int d0, idx0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

        #1;
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_dout_vld", 32'(dout_vld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Latency and throughput with ready held high.
        rdy_mode = 0; dout_rdy = 1'b1;
        d0 = done_cnt;
        issue_cmd(10'h010, 4);
        check("lat_busy", 32'(busy), 1);
        check("lat_rom_addr", 32'(rom_addr), 32'h010);
        check("lat_vld_e0", 32'(dout_vld), 0);
        tick();
        check("lat_vld_e1", 32'(dout_vld), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lat_vld", 32'(dout_vld), 1);
            check("lat_word", 32'(dout), 32'(ref_word(16, i)));
            check("lat_no_done", 32'(done), 0);
        end
        tick();
        check("lat_done", 32'(done), 1);
        check("lat_busy_fall", 32'(busy), 0);
        check("lat_vld_end", 32'(dout_vld), 0);
        tick();
        check("lat_done_once", 32'(done), 0);
        check("lat_done_cnt", done_cnt - d0, 1);

        // Zero-length command.
        d0 = done_cnt; idx0 = got.size();
        issue_cmd(10'h055, 0);
        check("z_busy", 32'(busy), 1);
        check("z_done", 32'(done), 1);
        check("z_vld", 32'(dout_vld), 0);
        tick(); tick();
        check("z_idle_busy", 32'(busy), 0);
        check("z_words", got.size() - idx0, 0);
        check("z_done_cnt", done_cnt - d0, 1);

        // Table of commands, with random or patterned backpressure.
        vecs.push_back('{10'h010, 4, 2, 0, 4});
        vecs.push_back('{10'h010, 4, 1, 50, 4});
        vecs.push_back('{10'h3FE, 4, 1, 100, 4});
        vecs.push_back('{10'h3FE, 4, 1, 30, 4});
        vecs.push_back('{10'h123, 1, 1, 100, 1});
        vecs.push_back('{10'h200, 17, 2, 0, 17});
        vecs.push_back('{10'h005, 1024, 1, 90, 1024});
        for (int i = 0; i < 6; i++) begin
            int n = $urandom_range(1, 40);
            vecs.push_back('{AW'($urandom), n, 1, $urandom_range(20, 100), n});
        end
        foreach (vecs[k]) begin
            rdy_mode = vecs[k].rdy_mode; rdy_pct = vecs[k].pct;
            d0 = done_cnt; idx0 = got.size();
            issue_cmd(vecs[k].base, vecs[k].n);
            finish_cmd(d0, idx0, int'(vecs[k].base), vecs[k].exp_words, 1'b0);
        end

        // A second start while busy is ignored.
        rdy_mode = 0; dout_rdy = 1'b1;
        d0 = done_cnt; idx0 = got.size();
        issue_cmd(10'h040, 8);
        base_addr = 10'h100; len = 11'd2; start = 1'b1;
        tick(); tick(); tick();
        start = 1'b0;
        finish_cmd(d0, idx0, 32'h040, 8, 1'b0);

        // Stop after two issues: only in-flight and buffered words follow.
        d0 = done_cnt; idx0 = got.size();
        issue_cmd(10'h0C0, 8);
        tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        finish_cmd(d0, idx0, 32'h0C0, 3, 1'b1);
        check("stop_some_words", 32'(got.size() - idx0 >= 1), 1);

        // Asynchronous reset with a full buffer.
        dout_rdy = 1'b0;
        d0 = done_cnt;
        issue_cmd(10'h080, 8);
        for (int i = 0; i < 5; i++) tick();
        check("rst_pre_vld", 32'(dout_vld), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(dout_vld), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_rom_addr", 32'(rom_addr), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("arst_no_done", done_cnt - d0, 0);
        check("arst_idle_vld", 32'(dout_vld), 0);
        rdy_mode = 1; rdy_pct = 60;
        d0 = done_cnt; idx0 = got.size();
        issue_cmd(10'h0AA, 5);
        finish_cmd(d0, idx0, 32'h0AA, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
